// File: rtl/muldiv_sequencer.sv
// Iterative 32-step multiply/divide unit that owns the HI/LO pair (MULT/MULTU/DIV/DIVU, MTHI/MTLO, MFHI/MFLO stall).
// Optional `MULDIV_DIVZERO_EN: early divide-by-zero completion with a divzero pulse.
module muldiv_sequencer #(
    parameter int WIDTH = 32,
    parameter int CNT_W = 5
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [1:0]       op,
    input  logic [WIDTH-1:0] srca,
    input  logic [WIDTH-1:0] srcb,
    input  logic             mthi,
    input  logic             mtlo,
    input  logic             rd_hi,
    input  logic             rd_lo,
    output logic             busy,
    output logic             done,
    output logic             stall,
    output logic [WIDTH-1:0] hi,
`ifdef MULDIV_DIVZERO_EN
    output logic             divzero,
`endif
    output logic [WIDTH-1:0] lo
);

    typedef enum logic [1:0] {IDLE, RUN, FIX} state_t;

    localparam logic [CNT_W-1:0] LAST_STEP = CNT_W'(WIDTH - 1);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q;
    logic [WIDTH-1:0]   acc_hi, acc_lo;   // product {hi,lo} or {remainder, quotient}
    logic [WIDTH-1:0]   a_reg, b_reg;     // multiplicand / multiplier-or-divisor magnitudes
    logic               is_div, res_neg, rem_neg;
    logic               dz_start;

    logic [WIDTH-1:0]   a_abs, b_abs;
    logic [WIDTH:0]     sum, rem_sh;
    logic [WIDTH-1:0]   diff;
    logic               ge;
    logic [2*WIDTH-1:0] prod, prod_neg;
    logic [WIDTH-1:0]   fix_hi, fix_lo;

    assign a_abs = (op[0] && srca[WIDTH-1]) ? -srca : srca;
    assign b_abs = (op[0] && srcb[WIDTH-1]) ? -srcb : srcb;

`ifdef MULDIV_DIVZERO_EN
    logic dz_q;
    assign dz_start = op[1] && (srcb == '0);
`else
    assign dz_start = 1'b0;
`endif

    assign busy  = (state_q != IDLE);
    assign stall = busy && (rd_hi || rd_lo);

    // NOTE: every always_comb output gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (start) state_d = dz_start ? FIX : RUN;
            RUN:     if (cnt_q == LAST_STEP) state_d = FIX;
            FIX:     state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        sum    = {1'b0, acc_hi} + (b_reg[0] ? {1'b0, a_reg} : '0);
        rem_sh = {acc_hi, acc_lo[WIDTH-1]};
        ge     = (rem_sh >= {1'b0, b_reg});
        // Result is below the divisor whenever it is kept, so WIDTH bits suffice.
        diff   = rem_sh[WIDTH-1:0] - b_reg;
    end

    always_comb begin
        prod     = {acc_hi, acc_lo};
        prod_neg = -prod;
        if (is_div) begin
            fix_lo = res_neg ? -acc_lo : acc_lo;
            fix_hi = rem_neg ? -acc_hi : acc_hi;
        end else begin
            {fix_hi, fix_lo} = res_neg ? prod_neg : prod;
        end
`ifdef MULDIV_DIVZERO_EN
        if (dz_q) begin
            fix_hi = acc_hi;
            fix_lo = acc_lo;
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // NOTE: all datapath registers are reset so an aborted operation leaves nothing behind.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt_q   <= '0;
            acc_hi  <= '0;
            acc_lo  <= '0;
            a_reg   <= '0;
            b_reg   <= '0;
            is_div  <= 1'b0;
            res_neg <= 1'b0;
            rem_neg <= 1'b0;
            hi      <= '0;
            lo      <= '0;
            done    <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            dz_q    <= 1'b0;
            divzero <= 1'b0;
`endif
        end else begin
            done <= 1'b0;
`ifdef MULDIV_DIVZERO_EN
            divzero <= 1'b0;
`endif
            case (state_q)
                IDLE: begin
                    if (start) begin
                        is_div  <= op[1];
                        res_neg <= op[0] && (srca[WIDTH-1] ^ srcb[WIDTH-1]);
                        rem_neg <= op[0] && srca[WIDTH-1];
                        a_reg   <= a_abs;
                        b_reg   <= b_abs;
                        cnt_q   <= '0;
                        acc_hi  <= '0;
                        acc_lo  <= op[1] ? a_abs : '0;
`ifdef MULDIV_DIVZERO_EN
                        dz_q    <= dz_start;
                        if (dz_start) begin
                            acc_hi <= srca;
                            acc_lo <= '1;
                        end
`endif
                    end else begin
                        if (mthi) hi <= srca;
                        if (mtlo) lo <= srca;
                    end
                end
                RUN: begin
                    cnt_q <= cnt_q + 1'b1;
                    if (is_div) begin
                        acc_hi <= ge ? diff : rem_sh[WIDTH-1:0];
                        acc_lo <= {acc_lo[WIDTH-2:0], ge};
                    end else begin
                        acc_hi <= sum[WIDTH:1];
                        acc_lo <= {sum[0], acc_lo[WIDTH-1:1]};
                        b_reg  <= b_reg >> 1;
                    end
                end
                FIX: begin
                    hi   <= fix_hi;
                    lo   <= fix_lo;
                    done <= 1'b1;
`ifdef MULDIV_DIVZERO_EN
                    divzero <= dz_q;
`endif
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_muldiv_sequencer.sv
// Self-checking bench for muldiv_sequencer: directed cases plus random ops against an arithmetic reference model.
module tb_muldiv_sequencer;

    logic        clk = 1'b0;
    logic        reset, start, mthi, mtlo, rd_hi, rd_lo;
    logic [1:0]  op;
    logic [31:0] srca, srcb;
    logic        busy, done, stall;
    logic [31:0] hi, lo;
`ifdef MULDIV_DIVZERO_EN
    logic        divzero;
`endif

    int passes = 0;
    int total  = 0;
    logic [31:0] m_hi, m_lo;

    muldiv_sequencer #(.WIDTH(32), .CNT_W(5)) dut (
        .clk(clk), .reset(reset), .start(start), .op(op), .srca(srca), .srcb(srcb),
        .mthi(mthi), .mtlo(mtlo), .rd_hi(rd_hi), .rd_lo(rd_lo),
        .busy(busy), .done(done), .stall(stall), .hi(hi),
`ifdef MULDIV_DIVZERO_EN
        .divzero(divzero),
`endif
        .lo(lo)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    endtask

    function automatic void model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                                  output logic [31:0] eh, output logic [31:0] el);
        logic [63:0] p;
        longint sa, sb, q, r;
        sa = longint'($signed(a));
        sb = longint'($signed(b));
        eh = '0;
        el = '0;
        case (o)
            2'b00: begin p = {32'b0, a} * {32'b0, b}; {eh, el} = p; end
            2'b01: begin p = 64'(sa * sb); {eh, el} = p; end
            2'b10: if (b == 0) begin eh = a; el = '1; end
                   else begin el = a / b; eh = a % b; end
            default: if (b == 0) begin eh = a; el = a[31] ? 32'd1 : 32'hFFFF_FFFF; end
                     else begin q = sa / sb; r = sa % sb; el = q[31:0]; eh = r[31:0]; end
        endcase
`ifdef MULDIV_DIVZERO_EN
        if (o[1] && b == 0) begin eh = a; el = '1; end
`endif
    endfunction

    task automatic mt_write(input bit to_hi, input logic [31:0] v);
        @(negedge clk);
        mthi = to_hi; mtlo = !to_hi; srca = v;
        @(posedge clk); #1;
        mthi = 0; mtlo = 0;
        if (to_hi) m_hi = v; else m_lo = v;
        check("mt_hi", hi, m_hi);
        check("mt_lo", lo, m_lo);
    endtask

    // Runs one operation; optionally asserts mthi with start, and re-starts (with an mtlo) at a RUN step.
    task automatic run_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                          input bit with_mthi, input int restart_step);
        logic [31:0] eh, el;
        int lat, n;
        model(o, a, b, eh, el);
        lat = 33;
`ifdef MULDIV_DIVZERO_EN
        if (o[1] && b == 0) lat = 1;
`endif
        @(negedge clk);
        start = 1; op = o; srca = a; srcb = b; mthi = with_mthi;
        @(posedge clk); #1;
        start = 0; mthi = 0;
        n = 0;
        while (done !== 1'b1 && n < 100) begin
            check("run_busy", busy, 1'b1);
            check("run_stall", stall, rd_hi | rd_lo);
            check("run_hi_hold", hi, m_hi);
            check("run_lo_hold", lo, m_lo);
            if (restart_step != 0 && n == restart_step) begin
                start = 1; op = ~o; srca = ~a; srcb = b + 7; mtlo = 1;
            end
            @(posedge clk); #1;
            start = 0; mtlo = 0;
            n++;
        end
        check("latency", 32'(n), 32'(lat));
        check("done_pulse", done, 1'b1);
        check("done_busy", busy, 1'b0);
        check("done_stall", stall, 1'b0);
        check("result_hi", hi, eh);
        check("result_lo", lo, el);
`ifdef MULDIV_DIVZERO_EN
        check("divzero", divzero, (o[1] && b == 0));
`endif
        m_hi = eh;
        m_lo = el;
        @(posedge clk); #1;
        check("done_single", done, 1'b0);
    endtask

    initial begin
        logic [1:0]  ro;
        logic [31:0] ra, rb;
        bit          seen_done;

        reset = 1; start = 0; mthi = 0; mtlo = 0; rd_hi = 0; rd_lo = 0;
        op = 0; srca = 0; srcb = 0;
        m_hi = 0; m_lo = 0;
        #12;
        check("rst_hi", hi, 32'h0);
        check("rst_lo", lo, 32'h0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_stall", stall, 1'b0);
        @(negedge clk); reset = 0;

        // Directed arithmetic cases, checked against literal values too.
        run_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0, 0);
        check("multu_max_hi", hi, 32'hFFFF_FFFE);
        check("multu_max_lo", lo, 32'h0000_0001);
        run_op(2'b01, -32'sd3, 32'd7, 0, 0);
        check("mult_neg_lo", lo, 32'hFFFF_FFEB);
        run_op(2'b11, -32'sd7, 32'd2, 0, 0);
        check("div_neg_lo", lo, 32'hFFFF_FFFD);
        check("div_neg_hi", hi, 32'hFFFF_FFFF);
        run_op(2'b10, 32'd100, 32'd7, 0, 0);
        check("divu_lo", lo, 32'd14);
        check("divu_hi", hi, 32'd2);
        run_op(2'b11, 32'h8000_0000, 32'hFFFF_FFFF, 0, 0);
        check("div_ovf_lo", lo, 32'h8000_0000);
        check("div_ovf_hi", hi, 32'h0);

        // MTLO then MULT with MFLO pending: stall through RUN, release in done cycle.
        mt_write(0, 32'h1234);
        mt_write(1, 32'hCAFE);
        rd_lo = 1;
        run_op(2'b01, 32'd2, 32'd3, 0, 0);
        check("stall_mult_lo", lo, 32'd6);
        rd_lo = 0;

        // mthi alongside start is dropped; a second start and mtlo mid-RUN are ignored.
        run_op(2'b01, 32'd5, 32'd6, 1, 12);

        // Reset during RUN step 10 discards the operation.
        @(negedge clk);
        start = 1; op = 2'b10; srca = 32'd1000; srcb = 32'd7;
        @(posedge clk); #1;
        start = 0;
        repeat (10) @(posedge clk);
        #2 reset = 1;
        #1;
        check("abort_busy", busy, 1'b0);
        check("abort_hi", hi, 32'h0);
        check("abort_lo", lo, 32'h0);
        check("abort_done", done, 1'b0);
        @(negedge clk); reset = 0;
        m_hi = 0; m_lo = 0;
        seen_done = 0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) seen_done = 1;
        end
        check("abort_no_done", 32'(seen_done), 32'h0);
        run_op(2'b10, 32'd9, 32'd3, 0, 0);

        // Divide by zero.
        run_op(2'b10, 32'd5, 32'd0, 0, 0);
        check("divz_lo", lo, 32'hFFFF_FFFF);
        check("divz_hi", hi, 32'd5);

        // Random operations with occasional MT writes and MFHI/MFLO requests.
        for (int i = 0; i < 25; i++) begin
            ro = 2'($urandom_range(0, 3));
            ra = $urandom;
            case ($urandom_range(0, 5))
                0:       rb = 32'h0;
                1, 2:    rb = 32'($urandom_range(1, 20));
                default: rb = $urandom;
            endcase
            if ($urandom_range(0, 3) == 0) mt_write(1'($urandom_range(0, 1)), $urandom);
            rd_hi = 1'($urandom_range(0, 1));
            rd_lo = 1'($urandom_range(0, 1));
            run_op(ro, ra, rb, 0, 0);
            rd_hi = 0;
            rd_lo = 0;
        end

        $display("%0d/%0d checks passed", passes, total);
        $finish;
    end

endmodule
